// File: rtl/boot_pkg.sv
// Shared types and byte constants for the UART boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0] START_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE   = 8'h06;
  localparam logic [7:0] NAK_BYTE   = 8'h15;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Bundle of UART rx/tx handshake, instruction-memory write port and core status.
interface uart_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  modport master (
    input  rx_valid, rx_byte, tx_busy,
    output tx_start, tx_byte, imem_we, imem_addr, imem_wdata,
           cpu_hold, load_done, load_error
  );

  modport slave (
    output rx_valid, rx_byte, tx_busy,
    input  tx_start, tx_byte, imem_we, imem_addr, imem_wdata,
           cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/boot_word_packer.sv
// Collects four little-endian bytes into a 32-bit word; word/word_ready are
// combinational in the cycle of the 4th byte so the caller can register them.
module boot_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  assign word_ready = valid && (byte_cnt == 2'd3);
  assign word       = {byte_in, shreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
    end else if (valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {byte_in, shreg[23:8]};
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Frame receiver that loads instruction memory over UART and gates the core's reset.
//   state | meaning
//   IDLE  | core held, waiting for START (also where errors land)
//   LEN0  | expecting word-count low byte
//   LEN1  | expecting word-count high byte, range check
//   DATA  | packing bytes into words, writing imem
//   CSUM  | comparing checksum byte with running sum
//   DONE  | image good, core released until next START
//   ERROR | transient; error handling goes straight back to IDLE
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_WORDS_LOG2 = 6,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_boot_loader_if.master    bus
);

  localparam int          IW        = IMEM_WORDS_LOG2 + 1;
  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_WORDS_LOG2;

  state_e          state;
  logic [15:0]     len;
  logic [IW-1:0]   word_index;
  logic [7:0]      sum;
  logic [TW-1:0]   tmo_cnt;
  logic            pending;
  logic [7:0]      resp_byte;

  logic            frame_start;
  logic            byte_valid;
  logic            word_ready;
  logic [31:0]     word;
  logic            tmo_active;
  logic            tmo_hit;
  logic [15:0]     len_next;
  logic            len_bad;
  logic            csum_ok;
  logic            csum_bad;
  logic            err_now;
  logic            last_word;

  always_comb begin
    frame_start = bus.rx_valid && (bus.rx_byte == START_BYTE) &&
                  ((state == IDLE) || (state == DONE));
    byte_valid  = bus.rx_valid && (state == DATA);
    tmo_active  = (state == LEN0) || (state == LEN1) ||
                  (state == DATA) || (state == CSUM);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    tmo_hit     = tmo_active && !bus.rx_valid && (tmo_cnt == TW'(1));
    len_next    = {bus.rx_byte, len[7:0]};
    len_bad     = (state == LEN1) && bus.rx_valid && ({1'b0, len_next} > MAX_WORDS);
    csum_ok     = (state == CSUM) && bus.rx_valid && (bus.rx_byte == sum);
    csum_bad    = (state == CSUM) && bus.rx_valid && (bus.rx_byte != sum);
    err_now     = tmo_hit || len_bad || csum_bad;
    last_word   = (16'(word_index) == (len - 16'd1));
  end

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (frame_start),
    .valid      (byte_valid),
    .byte_in    (bus.rx_byte),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      len            <= 16'd0;
      word_index     <= '0;
      sum            <= 8'd0;
      tmo_cnt        <= '0;
      pending        <= 1'b0;
      resp_byte      <= 8'd0;
      bus.tx_start   <= 1'b0;
      bus.tx_byte    <= 8'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= 32'd0;
      bus.imem_wdata <= 32'd0;
      bus.cpu_hold   <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.imem_we  <= 1'b0;

      if (pending && !bus.tx_busy) begin
        bus.tx_start <= 1'b1;
        bus.tx_byte  <= resp_byte;
        pending      <= 1'b0;
      end

      if (word_ready) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= {{(30 - IW){1'b0}}, word_index, 2'b00};
        bus.imem_wdata <= word;
      end

      if (bus.rx_valid) begin
        tmo_cnt <= TMO_LOAD;
      end else if (tmo_active && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (frame_start) begin
            state          <= LEN0;
            word_index     <= '0;
            sum            <= 8'd0;
            bus.cpu_hold   <= 1'b1;
            bus.load_done  <= 1'b0;
            bus.load_error <= 1'b0;
          end
        end
        LEN0: begin
          if (bus.rx_valid) begin
            len[7:0] <= bus.rx_byte;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (bus.rx_valid) begin
            len[15:8] <= bus.rx_byte;
            if (!len_bad) state <= (len_next == 16'd0) ? CSUM : DATA;
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            sum <= sum + bus.rx_byte;
            if (word_ready) begin
              word_index <= word_index + IW'(1);
              if (last_word) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (csum_ok) begin
            state         <= DONE;
            bus.cpu_hold  <= 1'b0;
            bus.load_done <= 1'b1;
            pending       <= 1'b1;
            resp_byte     <= ACK_BYTE;
          end
        end
        default: state <= IDLE;
      endcase

      // Errors override whatever the state branch chose; written words are kept.
      if (err_now) begin
        state          <= IDLE;
        bus.cpu_hold   <= 1'b1;
        bus.load_done  <= 1'b0;
        bus.load_error <= 1'b1;
        pending        <= 1'b1;
        resp_byte      <= NAK_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frames, error paths, timeout, tx queue and reset abort.
module tb_uart_boot_loader;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];

  uart_boot_loader_if bus ();

  uart_boot_loader #(
    .IMEM_WORDS_LOG2 (6),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
    if (bus.tx_start) tx_q.push_back(bus.tx_byte);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.cpu_hold !== 1'b1) begin
      errors++; $display("FAIL reset_cpu_hold got=%b exp=1", bus.cpu_hold);
    end
    vectors++;
    if ({bus.tx_start, bus.imem_we, bus.load_done, bus.load_error} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000",
                         {bus.tx_start, bus.imem_we, bus.load_done, bus.load_error});
    end
    vectors++;
    if ({bus.tx_byte, bus.imem_addr, bus.imem_wdata} !== 72'd0) begin
      errors++; $display("FAIL reset_data tx=%h addr=%h wdata=%h exp all 0",
                         bus.tx_byte, bus.imem_addr, bus.imem_wdata);
    end
  endtask

  task automatic check_two_words(input string tag);
    vectors++;
    if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL %s_write_count got=%0d exp=2", tag, wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h0000_0013) begin
        errors++; $display("FAIL %s_word0 got=%h@%h exp=00000013@00000000", tag, wr_data_q[0], wr_addr_q[0]);
      end
      vectors++;
      if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h0010_0093) begin
        errors++; $display("FAIL %s_word1 got=%h@%h exp=00100093@00000004", tag, wr_data_q[1], wr_addr_q[1]);
      end
    end
  endtask

  task automatic send_image(input logic [7:0] csum, input string tag);
    logic [7:0] frame [12];
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    frame[11] = csum;
    for (int i = 0; i < 12; i++) begin
      send_byte(frame[i]);
      if (i == 6 || i == 10) begin
        vectors++;
        if (bus.imem_we !== 1'b1) begin
          errors++; $display("FAIL %s_we_timing byte=%0d got=%b exp=1", tag, i, bus.imem_we);
        end
      end
      if (i == 7) begin
        vectors++;
        if (bus.imem_we !== 1'b0) begin
          errors++; $display("FAIL %s_we_pulse got=%b exp=0", tag, bus.imem_we);
        end
      end
      if (i == 10) begin
        vectors++;
        if (bus.cpu_hold !== 1'b1) begin
          errors++; $display("FAIL %s_hold_during_load got=%b exp=1", tag, bus.cpu_hold);
        end
      end
    end
  endtask

  task automatic test_good_frame();
    clear_queues();
    send_image(8'hB6, "good");
    vectors++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold} !== 3'b100) begin
      errors++; $display("FAIL good_flags done/err/hold got=%b exp=100",
                         {bus.load_done, bus.load_error, bus.cpu_hold});
    end
    vectors++;
    if (bus.tx_start !== 1'b0) begin
      errors++; $display("FAIL good_tx_too_early got=%b exp=0", bus.tx_start);
    end
    idle(1);
    vectors++;
    if (bus.tx_start !== 1'b1 || bus.tx_byte !== 8'h06) begin
      errors++; $display("FAIL good_ack start=%b byte=%h exp=1/06", bus.tx_start, bus.tx_byte);
    end
    idle(3);
    check_two_words("good");
    vectors++;
    if (tx_q.size() !== 1) begin
      errors++; $display("FAIL good_tx_count got=%0d exp=1", tx_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    clear_queues();
    send_image(8'hB7, "badsum");
    vectors++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold} !== 3'b011) begin
      errors++; $display("FAIL badsum_flags done/err/hold got=%b exp=011",
                         {bus.load_done, bus.load_error, bus.cpu_hold});
    end
    idle(4);
    check_two_words("badsum");
    vectors++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h15) begin
      errors++; $display("FAIL badsum_nak count=%0d first=%h exp=1/15", tx_q.size(),
                         (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_len_overflow();
    clear_queues();
    send_byte(8'hA5);
    vectors++;
    if (bus.load_error !== 1'b0) begin
      errors++; $display("FAIL start_clears_error got=%b exp=0", bus.load_error);
    end
    send_byte(8'h41);
    send_byte(8'h00);
    vectors++;
    if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b1) begin
      errors++; $display("FAIL len_overflow err=%b hold=%b exp=1/1", bus.load_error, bus.cpu_hold);
    end
    idle(4);
    vectors++;
    if (wr_addr_q.size() !== 0) begin
      errors++; $display("FAIL len_overflow_writes got=%0d exp=0", wr_addr_q.size());
    end
    vectors++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h15) begin
      errors++; $display("FAIL len_overflow_nak count=%0d exp=1 of 15", tx_q.size());
    end
  endtask

  task automatic test_timeout();
    clear_queues();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(99);
    vectors++;
    if (bus.load_error !== 1'b0) begin
      errors++; $display("FAIL timeout_early got=%b exp=0 after 99 idle cycles", bus.load_error);
    end
    idle(1);
    vectors++;
    if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b1) begin
      errors++; $display("FAIL timeout_expiry err=%b hold=%b exp=1/1", bus.load_error, bus.cpu_hold);
    end
    idle(4);
    vectors++;
    if (wr_addr_q.size() !== 0 || tx_q.size() !== 1 || tx_q[0] !== 8'h15) begin
      errors++; $display("FAIL timeout_nak writes=%0d tx=%0d exp=0/1 of 15", wr_addr_q.size(), tx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    vectors++;
    if (bus.load_error !== 1'b1 || bus.load_done !== 1'b0) begin
      errors++; $display("FAIL garbage_ignored err=%b done=%b exp=1/0", bus.load_error, bus.load_done);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    vectors++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold} !== 3'b100) begin
      errors++; $display("FAIL empty_frame done/err/hold got=%b exp=100",
                         {bus.load_done, bus.load_error, bus.cpu_hold});
    end
    idle(3);
    vectors++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h06) begin
      errors++; $display("FAIL empty_frame_ack count=%0d exp=1 of 06", tx_q.size());
    end
    clear_queues();
    bus.tx_busy = 1'b1;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    idle(10);
    vectors++;
    if (tx_q.size() !== 0) begin
      errors++; $display("FAIL busy_held count=%0d exp=0", tx_q.size());
    end
    bus.tx_busy = 1'b0;
    idle(5);
    vectors++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h15) begin
      errors++; $display("FAIL busy_overwrite count=%0d first=%h exp=1/15", tx_q.size(),
                         (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93);
    reset = 1'b1;
    #2;
    test_reset();
    vectors++;
    if (bus.load_error !== 1'b0) begin
      errors++; $display("FAIL midreset_error got=%b exp=0", bus.load_error);
    end
    idle(2);
    reset = 1'b0;
    clear_queues();
    idle(3);
    vectors++;
    if (tx_q.size() !== 0) begin
      errors++; $display("FAIL midreset_no_nak count=%0d exp=0", tx_q.size());
    end
    test_good_frame();
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    idle(2);
    test_good_frame();
    test_bad_checksum();
    test_len_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
